// File: rtl/sequence_pattern_generator.sv
// Serial pattern generator: shifts out one WIDTH-bit pattern per start request.
// Optional SEQ_GEN_REPEAT_EN adds repeat_en for back-to-back pattern repetition.
module sequence_pattern_generator #(
  parameter int                 WIDTH     = 4,
  parameter logic [WIDTH-1:0]   PATTERN   = WIDTH'(4'b1011),
  parameter bit                 MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_pattern,
`ifdef SEQ_GEN_REPEAT_EN
  input  logic             repeat_en,
`endif
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pattern_q, pattern_d;
  logic [WIDTH-1:0] shift_q, shift_d, shifted;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rep;

`ifdef SEQ_GEN_REPEAT_EN
  assign rep = repeat_en;
`else
  assign rep = 1'b0;
`endif

  // The bit on the wire always sits at the exit end of the shift register.
  assign shifted = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pattern_q <= PATTERN;
      shift_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (load_en) pattern_d = load_pattern;
        if (start) begin
          state_d = SEND;
          // A same-cycle load is what gets sent.
          shift_d = load_en ? load_pattern : pattern_q;
          cnt_d   = '0;
        end
      end
      SEND: begin
        shift_d = shifted;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          if (rep) begin
            shift_d = pattern_q;
            cnt_d   = '0;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign out_valid = (state_q == SEND);
  assign out       = out_valid & (MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0]);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_sequence_pattern_generator.sv
// Directed bench: MSB-first and LSB-first instances share stimulus; a 1011
// Moore detector model watches the MSB-first stream.
module tb_sequence_pattern_generator;
  logic       clk = 1'b0;
  logic       reset, start, load_en;
  logic [3:0] load_pattern;
  logic       out, out_valid, busy, done;
  logic       out_l, out_valid_l, busy_l, done_l;
`ifdef SEQ_GEN_REPEAT_EN
  logic       repeat_en = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sequence_pattern_generator dut (
    .clk(clk), .reset(reset), .start(start), .load_en(load_en), .load_pattern(load_pattern),
`ifdef SEQ_GEN_REPEAT_EN
    .repeat_en(repeat_en),
`endif
    .out(out), .out_valid(out_valid), .busy(busy), .done(done));

  sequence_pattern_generator #(.MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .start(start), .load_en(load_en), .load_pattern(load_pattern),
`ifdef SEQ_GEN_REPEAT_EN
    .repeat_en(1'b0),
`endif
    .out(out_l), .out_valid(out_valid_l), .busy(busy_l), .done(done_l));

  // Moore 1011 detector model consuming the serial stream
  logic [2:0] hist;
  int         det_cnt;
  always @(posedge clk) begin
    if (reset) begin
      hist    <= '0;
      det_cnt <= 0;
    end else if (out_valid) begin
      hist <= {hist[1:0], out};
      if ({hist, out} == 4'b1011) det_cnt <= det_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; load_en = 1'b0; load_pattern = '0;
    tick(); tick();
    reset = 1'b0;
    checks++;
    if ({out, out_valid, busy, done} !== 4'b0000) begin
      failures++; $display("FAIL reset_outputs: got %b want 0000", {out, out_valid, busy, done});
    end
  endtask

  task automatic test_default();
    logic [3:0] pm, pl;
    pm = 4'b1011; pl = 4'b1011;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({out, out_valid, busy, done} !== {pm[3-i], 3'b110}) begin
        failures++; $display("FAIL default_bit%0d: got %b want %b", i, {out, out_valid, busy, done}, {pm[3-i], 3'b110});
      end
      checks++;
      if ({out_l, out_valid_l} !== {pl[i], 1'b1}) begin
        failures++; $display("FAIL lsb_bit%0d: got %b want %b", i, {out_l, out_valid_l}, {pl[i], 1'b1});
      end
      if (i == 3) begin
        checks++;
        if (det_cnt !== 0) begin failures++; $display("FAIL detector_early: got %0d want 0", det_cnt); end
      end
      tick();
    end
    checks++;
    if ({out, out_valid, busy, done} !== 4'b0011) begin
      failures++; $display("FAIL default_done: got %b want 0011", {out, out_valid, busy, done});
    end
    checks++;
    if (det_cnt !== 1) begin failures++; $display("FAIL detector_hits: got %0d want 1", det_cnt); end
    tick();
    checks++;
    if ({out, out_valid, busy, done} !== 4'b0000) begin
      failures++; $display("FAIL default_idle: got %b want 0000", {out, out_valid, busy, done});
    end
  endtask

  task automatic test_load();
    logic [3:0] p;
    p = 4'b0110;
    load_en = 1'b1; load_pattern = 4'b0110; tick(); load_en = 1'b0;
    for (int t = 0; t < 2; t++) begin
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 4; i++) begin
        checks++;
        if ({out, out_valid} !== {p[3-i], 1'b1}) begin
          failures++; $display("FAIL load_t%0d_bit%0d: got %b want %b", t, i, {out, out_valid}, {p[3-i], 1'b1});
        end
        if (i == 1) begin load_en = 1'b1; load_pattern = 4'b1111; end
        tick();
      end
      load_en = 1'b0;
      checks++;
      if (done !== 1'b1) begin failures++; $display("FAIL load_t%0d_done: got %b want 1", t, done); end
      tick();
    end
    // load and start in the same cycle send the new value
    p = 4'b1001;
    load_en = 1'b1; load_pattern = 4'b1001; start = 1'b1; tick();
    load_en = 1'b0; start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({out, out_valid} !== {p[3-i], 1'b1}) begin
        failures++; $display("FAIL load_same_bit%0d: got %b want %b", i, {out, out_valid}, {p[3-i], 1'b1});
      end
      tick();
    end
    tick();
  endtask

  task automatic test_start_held();
    int  starts[$];
    logic prev;
    prev = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 13; i++) begin
      tick();
      if (out_valid && !prev) starts.push_back(i);
      prev = out_valid;
    end
    start = 1'b0;
    checks++;
    if (starts.size() !== 3) begin
      failures++; $display("FAIL held_count: got %0d want 3", starts.size());
    end else begin
      checks++;
      if (starts[1] - starts[0] !== 6 || starts[2] - starts[1] !== 6) begin
        failures++; $display("FAIL held_spacing: got %0d,%0d want 6,6", starts[1] - starts[0], starts[2] - starts[1]);
      end
    end
    for (int i = 0; i < 20 && busy; i++) tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL held_idle_timeout: got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_abort();
    logic [3:0] p;
    p = 4'b1011;
    start = 1'b1; tick(); start = 1'b0; tick();
    // reset beats a simultaneous start and load
    reset = 1'b1; start = 1'b1; load_en = 1'b1; load_pattern = 4'b0000; tick();
    reset = 1'b0; start = 1'b0; load_en = 1'b0;
    checks++;
    if ({out, out_valid, busy, done} !== 4'b0000) begin
      failures++; $display("FAIL abort_outputs: got %b want 0000", {out, out_valid, busy, done});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({busy, done} !== 2'b00) begin failures++; $display("FAIL abort_quiet%0d: got %b want 00", i, {busy, done}); end
    end
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({out, out_valid} !== {p[3-i], 1'b1}) begin
        failures++; $display("FAIL abort_restore_bit%0d: got %b want %b", i, {out, out_valid}, {p[3-i], 1'b1});
      end
      tick();
    end
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL abort_restore_done: got %b want 1", done); end
    tick();
  endtask

`ifdef SEQ_GEN_REPEAT_EN
  task automatic test_repeat();
    logic [3:0] p;
    p = 4'b1011;
    repeat_en = 1'b1; start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      checks++;
      if ({out, out_valid, done} !== {p[3-(i%4)], 2'b10}) begin
        failures++; $display("FAIL repeat_bit%0d: got %b want %b", i, {out, out_valid, done}, {p[3-(i%4)], 2'b10});
      end
      if (i == 8) repeat_en = 1'b0;
      tick();
    end
    checks++;
    if ({out_valid, done} !== 2'b01) begin failures++; $display("FAIL repeat_done: got %b want 01", {out_valid, done}); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_default();
    test_load();
    test_start_held();
    test_reset_abort();
`ifdef SEQ_GEN_REPEAT_EN
    test_repeat();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
